// File: rtl/request_arbiter_rr.sv
// request_arbiter_rr
//   Round-robin arbiter sharing one resource among REQ_COUNT requesters.
//   A registered one-hot grant is held until the owner releases it, drops
//   its request, the arbiter is disabled, or MAX_HOLD cycles elapse.
//   The winner is also reported as a binary index for downstream mux select.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   enable       1 = arbitration allowed; 0 = no new grant, current grant aborted
//   req          request vector, bit i = requester i
//   release_gnt  granted requester finished (only looked at while granting)
//   gnt          one-hot grant, all zero when idle
//   gnt_index    binary index of the granted requester, 0 when idle
//   gnt_valid    high while a grant is active
//   timeout      one-cycle pulse when a grant was cut at MAX_HOLD
//
// State table
//   IDLE  | no grant; search from pointer for the next requester
//   GRANT | one requester owns the resource; hold_cnt counts its cycles

module request_arbiter_rr #(
  parameter int REQ_COUNT   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int MAX_HOLD    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [REQ_COUNT-1:0]   req,
  input  logic                   release_gnt,
  output logic [REQ_COUNT-1:0]   gnt,
  output logic [INDEX_WIDTH-1:0] gnt_index,
  output logic                   gnt_valid,
  output logic                   timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [REQ_COUNT-1:0]   gnt_q, gnt_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;

  logic                   found;
  logic [INDEX_WIDTH-1:0] winner;
  logic [INDEX_WIDTH-1:0] cand_idx;
  int                     cand;
  logic                   early_exit;
  logic                   hold_done;

  // Rotating search: first set request at pointer, pointer+1, ... (mod REQ_COUNT).
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < REQ_COUNT; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= REQ_COUNT) cand = cand - REQ_COUNT;
      cand_idx = INDEX_WIDTH'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  assign early_exit = release_gnt || !req[idx_q] || !enable;
  assign hold_done  = (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
        if (enable && found) begin
          state_d       = GRANT;
          idx_d         = winner;
          gnt_d[winner] = 1'b1;
          valid_d       = 1'b1;
        end
      end
      GRANT: begin
        if (early_exit || hold_done) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          hold_d    = '0;
          ptr_d     = (idx_q == INDEX_WIDTH'(REQ_COUNT - 1)) ? '0 : idx_q + INDEX_WIDTH'(1);
          // Pulse only when the hold limit alone ended the grant.
          timeout_d = !early_exit;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_index = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_request_arbiter_rr.sv
module tb_request_arbiter_rr;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic        release_gnt;
  logic [15:0] gnt;
  logic [3:0]  gnt_index;
  logic        gnt_valid;
  logic        timeout;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  request_arbiter_rr #(
    .REQ_COUNT  (16),
    .INDEX_WIDTH(4),
    .MAX_HOLD   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .release_gnt(release_gnt),
    .gnt        (gnt),
    .gnt_index  (gnt_index),
    .gnt_valid  (gnt_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_timeout);
    check({tag, " valid"}, 32'(gnt_valid), 32'd0);
    check({tag, " gnt"}, 32'(gnt), 32'd0);
    check({tag, " index"}, 32'(gnt_index), 32'd0);
    check({tag, " timeout"}, 32'(timeout), 32'(exp_timeout));
  endtask

  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " valid"}, 32'(gnt_valid), 32'd1);
    check({tag, " index"}, 32'(gnt_index), 32'(e));
    check({tag, " gnt"}, 32'(gnt), 32'd1 << e);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    req         = '0;
    release_gnt = 1'b0;
    #12;
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    step();

    // single request, one-edge latency, release
    enable = 1'b1;
    req    = 16'h0004;
    exp_q.push_back(2);
    step();
    pop_check("single");
    release_gnt = 1'b1;
    step();
    check_idle("single release", 1'b0);
    release_gnt = 1'b0;

    // async reset in the middle of a grant to idx 5
    req = 16'h0020;
    exp_q.push_back(5);
    step();
    pop_check("pre-reset");
    #2 rst_n = 1'b0;
    #1;
    check_idle("async reset", 1'b0);
    rst_n = 1'b1;
    req   = 16'hFFFF;
    exp_q.push_back(0);
    step();
    pop_check("post-reset");

    // round robin over all requesters, one idle cycle between grants
    for (int k = 1; k <= 16; k++) begin
      release_gnt = 1'b1;
      step();
      check_idle("rr gap", 1'b0);
      release_gnt = 1'b0;
      exp_q.push_back(k % 16);
      step();
      pop_check("rr");
    end

    // wrap and skip: get to idx 14, then 8001 -> 15, 0
    release_gnt = 1'b1;
    req         = 16'h4000;
    step();
    release_gnt = 1'b0;
    exp_q.push_back(14);
    step();
    pop_check("to14");
    release_gnt = 1'b1;
    req         = 16'h8001;
    step();
    release_gnt = 1'b0;
    exp_q.push_back(15);
    exp_q.push_back(0);
    step();
    pop_check("wrap15");
    release_gnt = 1'b1;
    step();
    release_gnt = 1'b0;
    step();
    pop_check("wrap0");

    // skip: after idx 8, 0101 -> 0 then 8
    release_gnt = 1'b1;
    req         = 16'h0100;
    step();
    release_gnt = 1'b0;
    exp_q.push_back(8);
    step();
    pop_check("to8");
    release_gnt = 1'b1;
    req         = 16'h0101;
    step();
    release_gnt = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(8);
    step();
    pop_check("skip0");
    release_gnt = 1'b1;
    step();
    release_gnt = 1'b0;
    step();
    pop_check("skip8");

    // timeout: pointer is 9, req 0011 -> idx 0 held 8 cycles then idx 4
    release_gnt = 1'b1;
    req         = 16'h0011;
    step();
    release_gnt = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(4);
    step();
    pop_check("hold c1");
    check("hold c1 timeout", 32'(timeout), 32'd0);
    for (int c = 2; c <= 8; c++) begin
      step();
      check("hold valid", 32'(gnt_valid), 32'd1);
      check("hold index", 32'(gnt_index), 32'd0);
      check("hold timeout", 32'(timeout), 32'd0);
    end
    step();
    check_idle("cut", 1'b1);
    step();
    pop_check("after timeout");
    check("after timeout pulse", 32'(timeout), 32'd0);
    release_gnt = 1'b1;
    step();
    check_idle("release idx4", 1'b0);
    release_gnt = 1'b0;

    // enable: disabled arbiter grants nothing; disable aborts a grant
    enable = 1'b0;
    req    = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      check("disabled valid", 32'(gnt_valid), 32'd0);
    end
    enable = 1'b1;
    req    = 16'h0008;
    exp_q.push_back(3);
    step();
    pop_check("en grant3");
    enable = 1'b0;
    req    = 16'hFFFF;
    step();
    check_idle("disable abort", 1'b0);
    enable = 1'b1;
    exp_q.push_back(4);
    step();
    pop_check("pointer after abort");

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
